rx_packet_sequencer: RTL and testbench

RX_PACKET_SEQUENCER -- requirements
Module: rx_packet_sequencer

---
 rtl/rx_packet_sequencer_pkg.sv | 27 ++
 rtl/rx_seq_counter.sv | 18 +
 rtl/rx_packet_sequencer.sv | 159 +++++++++++++++
 tb/tb_rx_packet_sequencer.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/rx_packet_sequencer_pkg.sv
// Shared types and constants for the USB RX packet sequencer.
// Holds the FSM state encoding, error codes, the SYNC pattern and the PID constants.
package rx_packet_sequencer_pkg;

   typedef enum logic [2:0] {
      S_IDLE, S_HUNT, S_PID, S_DATA, S_DRAIN, S_CHECK
   } rx_state_e;

   localparam logic [2:0] ERR_PID       = 3'd1;
   localparam logic [2:0] ERR_CRC       = 3'd2;
   localparam logic [2:0] ERR_TIMEOUT   = 3'd3;
   localparam logic [2:0] ERR_OVERFLOW  = 3'd4;
   localparam logic [2:0] ERR_EARLY_EOP = 3'd5;

   // KJKJKJKK decoded and shifted in LSB-first
   localparam logic [7:0] SYNC_PAT = 8'b1000_0000;

   localparam logic [3:0] PID_OUT   = 4'h1;
   localparam logic [3:0] PID_ACK   = 4'h2;
   localparam logic [3:0] PID_DATA0 = 4'h3;
   localparam logic [1:0] PID_HSK   = 2'b10;

   function automatic logic pid_check(input logic [7:0] b);
      return b[3:0] == ~b[7:4];
   endfunction

endpackage

// File: rtl/rx_seq_counter.sv
// Saturating up-counter with synchronous clear; clear has priority over enable.
module rx_seq_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr,
   input  logic         en,
   output logic [W-1:0] cnt
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                 cnt <= '0;
      else if (clr)               cnt <= '0;
      else if (en && cnt != '1)   cnt <= cnt + 1'b1;
   end

endmodule

// File: rtl/rx_packet_sequencer.sv
// USB receive packet sequencer: SYNC hunt, PID capture/check, data length guard,
// drain and CRC verdict. All pulse outputs are registered so reset forces them low.
module rx_packet_sequencer
   import rx_packet_sequencer_pkg::*;
#(
   parameter int TIMEOUT_CYC = 255,
   parameter int MAX_BITS    = 600
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       abort,
   input  logic       rx_arm,
   input  logic       bit_valid,
   input  logic       bit_in,
   input  logic       se0,
   input  logic       end_decode,
   input  logic       crc_ok,
   output logic       start_unstuffer,
   output logic       end_unstuffer,
   output logic       unstuff_abort,
   output logic [3:0] pid,
   output logic       rx_busy,
   output logic       pkt_done,
   output logic       pkt_err,
   output logic [2:0] err_code
);

   localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
   localparam int BC_W = 10;
   localparam logic [TO_W-1:0] TO_LAST   = TO_W'(TIMEOUT_CYC - 1);
   localparam logic [BC_W-1:0] BITS_LAST = BC_W'(MAX_BITS - 1);
   localparam logic [BC_W-1:0] PID_LAST  = BC_W'(7);

   rx_state_e       state, state_nxt;
   logic [7:0]      sr_q, sr_nxt, sr_shift;
   logic [3:0]      pid_nxt;
   logic [TO_W-1:0] to_cnt;
   logic [BC_W-1:0] bit_cnt;
   logic            start_nxt, end_nxt, abort_nxt, done_nxt, err_nxt;
   logic [2:0]      code_nxt;

   assign sr_shift = {bit_in, sr_q[7:1]};
   assign rx_busy  = (state != S_IDLE);

   // Bit counter spans PID and DATA: MAX_BITS is a post-SYNC total
   rx_seq_counter #(.W(TO_W)) u_timeout (
      .clk(clk), .rst_n(rst_n), .clr(state == S_IDLE),
      .en(state == S_HUNT), .cnt(to_cnt)
   );

   rx_seq_counter #(.W(BC_W)) u_bitcnt (
      .clk(clk), .rst_n(rst_n), .clr(state == S_IDLE),
      .en(bit_valid && (state == S_PID || state == S_DATA)), .cnt(bit_cnt)
   );

   always_comb begin
      state_nxt = state;
      sr_nxt    = sr_q;
      pid_nxt   = pid;
      start_nxt = 1'b0;
      end_nxt   = 1'b0;
      abort_nxt = 1'b0;
      done_nxt  = 1'b0;
      err_nxt   = 1'b0;
      code_nxt  = 3'd0;
      if (abort) begin
         state_nxt = S_IDLE;
         abort_nxt = 1'b1;
      end else begin
         case (state)
            S_IDLE: if (rx_arm) begin
               state_nxt = S_HUNT;
               sr_nxt    = '0;
               pid_nxt   = '0;
            end
            S_HUNT: begin
               if (bit_valid) sr_nxt = sr_shift;
               if (bit_valid && sr_shift == SYNC_PAT) begin
                  state_nxt = S_PID;
                  start_nxt = 1'b1;
               end else if (to_cnt == TO_LAST) begin
                  state_nxt = S_IDLE;
                  err_nxt   = 1'b1;
                  code_nxt  = ERR_TIMEOUT;
                  abort_nxt = 1'b1;
               end
            end
            S_PID: begin
               if (se0) begin
                  state_nxt = S_IDLE;
                  err_nxt   = 1'b1;
                  code_nxt  = ERR_EARLY_EOP;
                  abort_nxt = 1'b1;
               end else if (bit_valid) begin
                  sr_nxt = sr_shift;
                  if (bit_cnt == PID_LAST) begin
                     if (pid_check(sr_shift)) begin
                        state_nxt = S_DATA;
                        pid_nxt   = sr_shift[3:0];
                     end else begin
                        state_nxt = S_IDLE;
                        err_nxt   = 1'b1;
                        code_nxt  = ERR_PID;
                        abort_nxt = 1'b1;
                     end
                  end
               end
            end
            S_DATA: begin
               if (se0) begin
                  state_nxt = S_DRAIN;
                  end_nxt   = 1'b1;
               end else if (bit_valid && bit_cnt == BITS_LAST) begin
                  state_nxt = S_IDLE;
                  err_nxt   = 1'b1;
                  code_nxt  = ERR_OVERFLOW;
                  abort_nxt = 1'b1;
               end
            end
            S_DRAIN: if (end_decode) state_nxt = S_CHECK;
            S_CHECK: begin
               state_nxt = S_IDLE;
               // Handshakes carry no CRC, so the residue is meaningless for them
               if (pid[1:0] == PID_HSK || crc_ok) done_nxt = 1'b1;
               else begin
                  err_nxt  = 1'b1;
                  code_nxt = ERR_CRC;
               end
            end
            default: state_nxt = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state           <= S_IDLE;
         sr_q            <= '0;
         pid             <= '0;
         start_unstuffer <= 1'b0;
         end_unstuffer   <= 1'b0;
         unstuff_abort   <= 1'b0;
         pkt_done        <= 1'b0;
         pkt_err         <= 1'b0;
         err_code        <= 3'd0;
      end else begin
         state           <= state_nxt;
         sr_q            <= sr_nxt;
         pid             <= pid_nxt;
         start_unstuffer <= start_nxt;
         end_unstuffer   <= end_nxt;
         unstuff_abort   <= abort_nxt;
         pkt_done        <= done_nxt;
         pkt_err         <= err_nxt;
         err_code        <= code_nxt;
      end
   end

endmodule

// File: tb/tb_rx_packet_sequencer.sv
// Directed bench for rx_packet_sequencer: packet verdicts go through a scoreboard queue,
// pulse counts and timing boundaries are checked inline.
module tb_rx_packet_sequencer;
   import rx_packet_sequencer_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n, abort, rx_arm, bit_valid, bit_in, se0, end_decode, crc_ok;
   logic       start_unstuffer, end_unstuffer, unstuff_abort, rx_busy, pkt_done, pkt_err;
   logic [3:0] pid;
   logic [2:0] err_code;

   typedef struct { logic is_err; logic [2:0] code; } exp_t;
   exp_t sb[$];

   int tests = 0, fails = 0;
   int start_cnt = 0, end_cnt = 0, uab_cnt = 0;
   int s0, e0, a0;

   rx_packet_sequencer #(.TIMEOUT_CYC(255), .MAX_BITS(600)) dut (
      .clk(clk), .rst_n(rst_n), .abort(abort), .rx_arm(rx_arm),
      .bit_valid(bit_valid), .bit_in(bit_in), .se0(se0), .end_decode(end_decode),
      .crc_ok(crc_ok), .start_unstuffer(start_unstuffer), .end_unstuffer(end_unstuffer),
      .unstuff_abort(unstuff_abort), .pid(pid), .rx_busy(rx_busy),
      .pkt_done(pkt_done), .pkt_err(pkt_err), .err_code(err_code)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      if (start_unstuffer) start_cnt++;
      if (end_unstuffer)   end_cnt++;
      if (unstuff_abort)   uab_cnt++;
      if (pkt_done || pkt_err) begin
         chk("done_err_exclusive", {31'd0, pkt_done & pkt_err}, 0);
         if (sb.size() == 0) chk("unexpected_pulse", {31'd0, pkt_err}, 32'hdead);
         else begin
            exp_t e;
            e = sb.pop_front();
            chk("verdict_is_err", {31'd0, pkt_err}, {31'd0, e.is_err});
            if (e.is_err) chk("err_code", {29'd0, err_code}, {29'd0, e.code});
         end
      end
   end

   task automatic tick(input int n = 1);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic push(input logic is_err, input logic [2:0] code);
      exp_t e;
      e.is_err = is_err;
      e.code   = code;
      sb.push_back(e);
   endtask

   task automatic send_bit(input logic b, input logic with_se0 = 1'b0);
      bit_valid = 1'b1; bit_in = b; se0 = with_se0;
      tick();
      bit_valid = 1'b0; se0 = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] v);
      for (int i = 0; i < 8; i++) send_bit(v[i]);
   endtask

   task automatic send_rand(input int n);
      for (int i = 0; i < n; i++) send_bit(1'($urandom_range(0, 1)));
   endtask

   task automatic arm_sync(input logic [7:0] p);
      rx_arm = 1'b1; tick(); rx_arm = 1'b0;
      send_byte(SYNC_PAT);
      send_byte(p);
   endtask

   task automatic eop_finish(input logic crc);
      se0 = 1'b1; tick(); se0 = 1'b0;
      tick(2);
      crc_ok = crc;
      end_decode = 1'b1; tick(); end_decode = 1'b0;
      tick(3);
   endtask

   task automatic mark();
      s0 = start_cnt; e0 = end_cnt; a0 = uab_cnt;
   endtask

   initial begin
      rst_n = 1'b0; abort = 1'b0; rx_arm = 1'b0; bit_valid = 1'b0; bit_in = 1'b0;
      se0 = 1'b0; end_decode = 1'b0; crc_ok = 1'b0;
      tick(3);
      chk("reset_outputs", {start_unstuffer, end_unstuffer, unstuff_abort, pid, rx_busy,
                            pkt_done, pkt_err, err_code}, 0);
      rst_n = 1'b1;
      tick(2);

      // OUT packet, good CRC
      mark();
      push(1'b0, 3'd0);
      arm_sync({~PID_OUT, PID_OUT});
      chk("out_start_pulse", start_cnt - s0, 1);
      chk("out_busy", {31'd0, rx_busy}, 1);
      send_rand(19);
      eop_finish(1'b1);
      chk("out_end_pulse", end_cnt - e0, 1);
      chk("out_pid", {28'd0, pid}, {28'd0, PID_OUT});
      chk("out_idle", {31'd0, rx_busy}, 0);

      // Bad PID check field
      mark();
      push(1'b1, ERR_PID);
      arm_sync(8'b1111_0001);
      tick(2);
      chk("badpid_no_end", end_cnt - e0, 0);
      chk("badpid_abort", uab_cnt - a0, 1);
      chk("badpid_idle", {31'd0, rx_busy}, 0);

      // Timeout: error exactly on the 255th cycle after arming
      push(1'b1, ERR_TIMEOUT);
      rx_arm = 1'b1; tick(); rx_arm = 1'b0;
      tick(254);
      chk("timeout_not_early", {31'd0, pkt_err}, 0);
      chk("timeout_busy", {31'd0, rx_busy}, 1);
      tick();
      chk("timeout_err", {31'd0, pkt_err}, 1);
      chk("timeout_abort", {31'd0, unstuff_abort}, 1);
      tick(2);

      // Early EOP inside PID
      push(1'b1, ERR_EARLY_EOP);
      rx_arm = 1'b1; tick(); rx_arm = 1'b0;
      send_byte(SYNC_PAT);
      send_rand(3);
      se0 = 1'b1; tick(); se0 = 1'b0;
      tick(2);
      chk("eeop_idle", {31'd0, rx_busy}, 0);

      // DATA0 with bad CRC, then ACK with bad CRC
      push(1'b1, ERR_CRC);
      arm_sync({~PID_DATA0, PID_DATA0});
      send_rand(24);
      eop_finish(1'b0);
      push(1'b0, 3'd0);
      arm_sync({~PID_ACK, PID_ACK});
      eop_finish(1'b0);
      chk("ack_pid", {28'd0, pid}, {28'd0, PID_ACK});

      // Overflow: 8 PID bits + 592 data bits
      mark();
      push(1'b1, ERR_OVERFLOW);
      arm_sync({~PID_DATA0, PID_DATA0});
      send_rand(591);
      tick();
      chk("ovf_not_early", sb.size(), 1);
      send_bit(1'b1);
      tick(2);
      chk("ovf_no_end", end_cnt - e0, 0);
      chk("ovf_idle", {31'd0, rx_busy}, 0);

      // se0 on the 600th bit beats overflow
      mark();
      push(1'b0, 3'd0);
      arm_sync({~PID_DATA0, PID_DATA0});
      send_rand(591);
      send_bit(1'b0, 1'b1);
      tick();
      chk("se0_wins_end", end_cnt - e0, 1);
      chk("se0_wins_busy", {31'd0, rx_busy}, 1);
      crc_ok = 1'b1;
      end_decode = 1'b1; tick(); end_decode = 1'b0;
      tick(3);

      // Abort in DATA, then reset in DRAIN: no verdicts expected
      mark();
      arm_sync({~PID_OUT, PID_OUT});
      send_rand(5);
      abort = 1'b1; tick(); abort = 1'b0;
      chk("abort_pulse", {31'd0, unstuff_abort}, 1);
      chk("abort_idle", {31'd0, rx_busy}, 0);
      tick(2);
      arm_sync({~PID_OUT, PID_OUT});
      send_rand(4);
      se0 = 1'b1; tick(); se0 = 1'b0;
      tick();
      chk("drain_busy", {31'd0, rx_busy}, 1);
      rst_n = 1'b0;
      #1;
      chk("rst_outputs", {start_unstuffer, end_unstuffer, unstuff_abort, pid, rx_busy,
                          pkt_done, pkt_err}, 0);
      tick(2);
      rst_n = 1'b1;
      crc_ok = 1'b1;
      end_decode = 1'b1; tick(); end_decode = 1'b0;
      tick(5);
      chk("rst_end_count", end_cnt - e0, 1);
      chk("rst_abort_count", uab_cnt - a0, 1);
      chk("rst_idle", {31'd0, rx_busy}, 0);

      chk("scoreboard_drained", sb.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
